// File: rtl/reg_write_arbiter_pkg.sv
// Shared widths, request payload and grant encoding for the register-file write arbiter.
package reg_wr_arb_pkg;

  localparam int N_BITS = 32;
  localparam int DATA_W = N_BITS;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] rk,
                                    input logic [ADDR_W-1:0] addr,
                                    input logic              valid);
    return valid && (addr == rk);
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundles both writeback sources, the hazard read ports and the register-file write port.
interface reg_write_arbiter_if;
  import reg_wr_arb_pkg::*;

  logic              a_valid_i;
  logic              a_ready_o;
  logic [ADDR_W-1:0] a_addr_i;
  logic [DATA_W-1:0] a_data_i;
  logic              b_valid_i;
  logic              b_ready_o;
  logic [ADDR_W-1:0] b_addr_i;
  logic [DATA_W-1:0] b_data_i;
  logic [ADDR_W-1:0] read_register_1_i;
  logic [ADDR_W-1:0] read_register_2_i;
  logic              busy_1_o;
  logic              busy_2_o;
  logic              reg_write_o;
  logic [ADDR_W-1:0] write_register_o;
  logic [DATA_W-1:0] write_data_o;
  logic [CNT_W-1:0]  conflict_count_o;

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
           read_register_1_i, read_register_2_i,
    output a_ready_o, b_ready_o, busy_1_o, busy_2_o,
           reg_write_o, write_register_o, write_data_o, conflict_count_o
  );

  modport master (
    output a_valid_i, a_addr_i, a_data_i, b_valid_i, b_addr_i, b_data_i,
           read_register_1_i, read_register_2_i,
    input  a_ready_o, b_ready_o, busy_1_o, busy_2_o,
           reg_write_o, write_register_o, write_data_o, conflict_count_o
  );

endinterface

// File: rtl/reg_write_arbiter_wr_req_buffer.sv
// One-entry write-request holding buffer; 'young' marks an entry captured after the
// other source's still-pending entry, so same-address writes retire in order.
module wr_req_buffer
  import reg_wr_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  logic    drain,
  input  logic    other_valid,
  input  logic    other_drain,
  input  wr_req_t req_in,
  output logic    valid,
  output logic    young,
  output wr_req_t req
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      young <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      young <= other_valid & ~other_drain;
    end else if (drain) begin
      valid <= 1'b0;
      young <= 1'b0;
    end else if (other_drain) begin
      young <= 1'b0;
    end
  end

  // NOTE: payload is qualified by 'valid', so it carries no reset and stays a plain enable flop.
  always_ff @(posedge clk) begin
    if (load) req <= req_in;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-source arbiter for the MIPS register-file write port with hazard reporting.
// Optional contention counter: define REG_WR_ARB_CONFLICT_CNT_EN.
module reg_write_arbiter
  import reg_wr_arb_pkg::*;
(
  input logic               clk,
  input logic               reset,
  reg_write_arbiter_if.slave bus
);

  wr_req_t           a_q, b_q, gnt_req;
  logic              a_v, b_v, a_young, b_young;
  logic              a_drain, b_drain, a_ready, b_ready;
  grant_e            gnt;
  logic              last_b;
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;

  assign a_drain = (gnt == GNT_A);
  assign b_drain = (gnt == GNT_B);
  assign a_ready = ~a_v | a_drain;
  assign b_ready = ~b_v | b_drain;

  wr_req_buffer u_buf_a (
    .clk(clk), .reset(reset),
    .load(bus.a_valid_i & a_ready), .drain(a_drain),
    .other_valid(b_v), .other_drain(b_drain),
    .req_in('{addr: bus.a_addr_i, data: bus.a_data_i}),
    .valid(a_v), .young(a_young), .req(a_q)
  );

  wr_req_buffer u_buf_b (
    .clk(clk), .reset(reset),
    .load(bus.b_valid_i & b_ready), .drain(b_drain),
    .other_valid(a_v), .other_drain(a_drain),
    .req_in('{addr: bus.b_addr_i, data: bus.b_data_i}),
    .valid(b_v), .young(b_young), .req(b_q)
  );

  // NOTE: default assignment first keeps this purely combinational (no latch on any path).
  always_comb begin
    gnt = GNT_NONE;
    if (a_v && b_v) begin
      if (a_q.addr == b_q.addr)
        gnt = (b_young && !a_young) ? GNT_A : GNT_B;  // same-cycle capture ties to B, so A lands last
      else
        gnt = last_b ? GNT_A : GNT_B;
    end else if (a_v) begin
      gnt = GNT_A;
    end else if (b_v) begin
      gnt = GNT_B;
    end
  end

  assign gnt_req = b_drain ? b_q : a_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= REG_ZERO;
      write_data     <= '0;
      last_b         <= 1'b1;
    end else begin
      reg_write <= (gnt != GNT_NONE) && (gnt_req.addr != REG_ZERO);
      if (gnt != GNT_NONE) last_b <= b_drain;
      if ((gnt != GNT_NONE) && (gnt_req.addr != REG_ZERO)) begin
        write_register <= gnt_req.addr;
        write_data     <= gnt_req.data;
      end
    end
  end

  assign bus.a_ready_o        = a_ready;
  assign bus.b_ready_o        = b_ready;
  assign bus.reg_write_o      = reg_write;
  assign bus.write_register_o = write_register;
  assign bus.write_data_o     = write_data;

  assign bus.busy_1_o = (bus.read_register_1_i != REG_ZERO) &&
                        (addr_hit(bus.read_register_1_i, a_q.addr, a_v) ||
                         addr_hit(bus.read_register_1_i, b_q.addr, b_v) ||
                         addr_hit(bus.read_register_1_i, write_register, reg_write));
  assign bus.busy_2_o = (bus.read_register_2_i != REG_ZERO) &&
                        (addr_hit(bus.read_register_2_i, a_q.addr, a_v) ||
                         addr_hit(bus.read_register_2_i, b_q.addr, b_v) ||
                         addr_hit(bus.read_register_2_i, write_register, reg_write));

`ifdef REG_WR_ARB_CONFLICT_CNT_EN
  logic [CNT_W-1:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      conflict_cnt <= '0;
    else if (a_v && b_v && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + 1'b1;
  end

  assign bus.conflict_count_o = conflict_cnt;
`else
  assign bus.conflict_count_o = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized checks of reg_write_arbiter against a capture-time reference model.
module tb_reg_write_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_write_arbiter_if bus ();

  reg_write_arbiter dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: index 0 = source A, 1 = source B.
  logic        mv [2];
  logic [4:0]  ma [2];
  logic [31:0] md [2];
  int          ms [2];      // cycle in which the entry was captured
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_lastb;
  int          m_cnt;
  int          cyc;

  // Producer-side request registers.
  logic        req_v [2];
  logic [4:0]  req_a [2];
  logic [31:0] req_d [2];

  logic [31:0] mem_ref [32];
  logic [31:0] mem_dut [32];
  int          exp_writes;
  int          dut_writes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic int model_grant();
    if (!mv[0] && !mv[1]) return -1;
    if (mv[0] && !mv[1])  return 0;
    if (mv[1] && !mv[0])  return 1;
    if (ma[0] == ma[1])   return (ms[0] < ms[1]) ? 0 : 1;
    return m_lastb ? 0 : 1;
  endfunction

  function automatic logic model_busy(input logic [4:0] rk);
    return (rk != 0) && ((mv[0] && ma[0] == rk) || (mv[1] && ma[1] == rk) ||
                         (m_we && m_wa == rk));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0; ma[s] = '0; md[s] = '0; ms[s] = 0; req_v[s] = 1'b0;
    end
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_lastb = 1'b1; m_cnt = 0;
  endtask

  task automatic set_req(input int s, input logic [4:0] a, input logic [31:0] d);
    req_v[s] = 1'b1; req_a[s] = a; req_d[s] = d;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic tick(input logic rst);
    int   g;
    logic er  [2];
    logic acc [2];
    reset = rst;
    bus.a_valid_i = req_v[0]; bus.a_addr_i = req_a[0]; bus.a_data_i = req_d[0];
    bus.b_valid_i = req_v[1]; bus.b_addr_i = req_a[1]; bus.b_data_i = req_d[1];
    #1;
    g = model_grant();
    for (int s = 0; s < 2; s++) er[s] = !mv[s] || (g == s);
    check("reg_write", bus.reg_write_o, m_we);
    check("write_register", bus.write_register_o, m_wa);
    check("write_data", bus.write_data_o, m_wd);
    check("a_ready", bus.a_ready_o, er[0]);
    check("b_ready", bus.b_ready_o, er[1]);
    check("busy_1", bus.busy_1_o, model_busy(bus.read_register_1_i));
    check("busy_2", bus.busy_2_o, model_busy(bus.read_register_2_i));
    check("conflict_count", bus.conflict_count_o, m_cnt[15:0]);
    if (bus.reg_write_o === 1'b1) begin
      mem_dut[bus.write_register_o] = bus.write_data_o;
      dut_writes++;
    end
    if (m_we) mem_ref[m_wa] = m_wd;

    if (rst) begin
      for (int s = 0; s < 2; s++)
        if (mv[s] && ma[s] != 0) exp_writes--;
      model_reset();
    end else begin
      for (int s = 0; s < 2; s++) acc[s] = req_v[s] && er[s];
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
      if (mv[0] && mv[1] && m_cnt < 65535) m_cnt++;
`endif
      if (g >= 0) begin
        m_lastb = (g == 1);
        m_we    = (ma[g] != 0);
        if (m_we) begin
          m_wa = ma[g];
          m_wd = md[g];
        end
        mv[g] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          mv[s] = 1'b1; ma[s] = req_a[s]; md[s] = req_d[s]; ms[s] = cyc;
          if (req_a[s] != 0) exp_writes++;
          req_v[s] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    cyc = 0; exp_writes = 0; dut_writes = 0;
    for (int i = 0; i < 32; i++) begin
      mem_ref[i] = '0;
      mem_dut[i] = '0;
    end
    model_reset();
    reset = 1'b1;
    bus.a_valid_i = 1'b0; bus.a_addr_i = '0; bus.a_data_i = '0;
    bus.b_valid_i = 1'b0; bus.b_addr_i = '0; bus.b_data_i = '0;
    bus.read_register_1_i = 5'd9;
    bus.read_register_2_i = 5'd8;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check("rst_reg_write", bus.reg_write_o, 1'b0);
    check("rst_write_register", bus.write_register_o, 5'd0);
    check("rst_write_data", bus.write_data_o, 32'd0);
    check("rst_a_ready", bus.a_ready_o, 1'b1);
    check("rst_b_ready", bus.b_ready_o, 1'b1);
    check("rst_busy_1", bus.busy_1_o, 1'b0);
    check("rst_conflict", bus.conflict_count_o, 16'd0);

    // Simultaneous requests, different addresses: A wins the first contention.
    bus.read_register_1_i = 5'd16;
    set_req(0, 5'd8, 32'hA);
    set_req(1, 5'd16, 32'hB);
    tick(1'b0);
    check("diff_c1_a_ready", bus.a_ready_o, 1'b1);
    check("diff_c1_b_ready", bus.b_ready_o, 1'b0);
    tick(1'b0);
    check("diff_c2_we", bus.reg_write_o, 1'b1);
    check("diff_c2_addr", bus.write_register_o, 5'd8);
    check("diff_c2_data", bus.write_data_o, 32'hA);
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
    check("diff_c2_conflict", bus.conflict_count_o, 16'd1);
`endif
    tick(1'b0);
    check("diff_c3_addr", bus.write_register_o, 5'd16);
    check("diff_c3_data", bus.write_data_o, 32'hB);
    check("diff_c3_busy_1", bus.busy_1_o, 1'b1);
    tick(1'b0);

    // Single A write with hazard on read port 1.
    bus.read_register_1_i = 5'd9;
    set_req(0, 5'd9, 32'h1234);
    tick(1'b0);
    check("single_c1_busy", bus.busy_1_o, 1'b1);
    check("single_c1_we", bus.reg_write_o, 1'b0);
    tick(1'b0);
    check("single_c2_we", bus.reg_write_o, 1'b1);
    check("single_c2_addr", bus.write_register_o, 5'd9);
    check("single_c2_data", bus.write_data_o, 32'h1234);
    check("single_c2_busy", bus.busy_1_o, 1'b1);
    tick(1'b0);
    check("single_c3_we", bus.reg_write_o, 1'b0);
    check("single_c3_busy", bus.busy_1_o, 1'b0);

    // Same address, same cycle: B written first, A's value lands last.
    set_req(0, 5'd17, 32'h11);
    set_req(1, 5'd17, 32'h22);
    tick(1'b0);
    tick(1'b0);
    check("same_c2_data", bus.write_data_o, 32'h22);
    tick(1'b0);
    check("same_c3_data", bus.write_data_o, 32'h11);
    check("same_c3_we", bus.reg_write_o, 1'b1);
    tick(1'b0);

    // Write to $zero is dropped.
    bus.read_register_1_i = 5'd0;
    set_req(1, 5'd0, 32'hFFFF_FFFF);
    tick(1'b0);
    check("zero_c1_b_ready", bus.b_ready_o, 1'b1);
    check("zero_c1_busy", bus.busy_1_o, 1'b0);
    tick(1'b0);
    check("zero_c2_we", bus.reg_write_o, 1'b0);
    tick(1'b0);
    check("zero_c3_we", bus.reg_write_o, 1'b0);

    // Sustained contention with distinct addresses: A/B alternate.
    bus.read_register_1_i = 5'd3;
    for (int k = 0; k < 6; k++) begin
      if (!req_v[0]) set_req(0, 5'(1 + k), 32'h100 + k);
      if (!req_v[1]) set_req(1, 5'(20 + k), 32'h200 + k);
      tick(1'b0);
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (4) tick(1'b0);

    // Reset while both buffers are full.
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    tick(1'b0);
    set_req(0, 5'd5, 32'h55);
    tick(1'b0);
    tick(1'b1);
    check("mid_rst_we", bus.reg_write_o, 1'b0);
    check("mid_rst_addr", bus.write_register_o, 5'd0);
    check("mid_rst_data", bus.write_data_o, 32'd0);
    check("mid_rst_a_ready", bus.a_ready_o, 1'b1);
    check("mid_rst_b_ready", bus.b_ready_o, 1'b1);
    check("mid_rst_busy_1", bus.busy_1_o, 1'b0);
    check("mid_rst_conflict", bus.conflict_count_o, 16'd0);
    tick(1'b0);
    check("post_rst_we", bus.reg_write_o, 1'b0);

    // Randomized traffic on a small address range to provoke collisions.
    for (int k = 0; k < 400; k++) begin
      for (int s = 0; s < 2; s++)
        if (!req_v[s] && ($urandom_range(0, 9) < 6))
          set_req(s, 5'($urandom_range(0, 7)), $urandom);
      bus.read_register_1_i = 5'($urandom_range(0, 7));
      bus.read_register_2_i = 5'($urandom_range(0, 7));
      tick(1'b0);
    end
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    repeat (5) tick(1'b0);

    check("write_count", 64'(dut_writes), 64'(exp_writes));
    for (int i = 0; i < 32; i++)
      check($sformatf("regfile[%0d]", i), mem_dut[i], mem_ref[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
